// File: rtl/router_wght_rr.sv
// router_wght_rr
//
// Weight router for a PE array. Two independent jobs share this block:
//   1. Round-robin forwarding: every cycle one enabled input port is granted
//      and its word is broadcast, combinationally, to the output ports chosen
//      by route_mask.
//   2. Burst fetch: a burst request (rising edge of input traffic or of the
//      software start) reads BURST_LEN weights from the GLB. The responses
//      come back through the router ports and are written to the scratchpad.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   in_data_i        NUM_PORTS packed words, port k at [k*DW +: DW]
//   in_enable_i      per-port input valid
//   route_mask       output ports that receive the forwarded word
//   start            software burst trigger (edge detected)
//   out_data_o       forwarded words, same packing as in_data_i
//   out_enable_o     per-port forward valid
//   glb_addr_read    GLB read address
//   glb_req_read     GLB read request, one word per asserted cycle
//   spad_data_o      scratchpad write data (registered)
//   spad_addr_o      scratchpad write address, restarts at 0 every burst
//   spad_enable_o    scratchpad write strobe (registered)
//   busy             burst in progress
//   done             one-cycle end-of-burst pulse
//   drop             one-cycle pulse when a burst request arrives while busy
//
// Burst FSM
//   state | meaning
//   IDLE  | waiting for a burst request
//   READ  | issuing BURST_LEN GLB read requests, one per cycle
//   DRAIN | one cycle for the last GLB read response to land
//   DONE  | pulse done, advance (or wrap) the GLB base address

module router_wght_rr #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int NUM_PORTS         = 4,
    parameter int BURST_LEN         = 9,
    parameter int NUM_BURSTS        = 4,
    parameter int W_READ_ADDR       = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS*DATA_BITWIDTH-1:0]   in_data_i,
    input  logic [NUM_PORTS-1:0]                 in_enable_i,
    input  logic [NUM_PORTS-1:0]                 route_mask,
    input  logic                                 start,
    output logic [NUM_PORTS*DATA_BITWIDTH-1:0]   out_data_o,
    output logic [NUM_PORTS-1:0]                 out_enable_o,
    output logic [ADDR_BITWIDTH_GLB-1:0]         glb_addr_read,
    output logic                                 glb_req_read,
    output logic [DATA_BITWIDTH-1:0]             spad_data_o,
    output logic [ADDR_BITWIDTH_SPAD-1:0]        spad_addr_o,
    output logic                                 spad_enable_o,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 drop
);

    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // One extra code so the counters can hold BURST_LEN / NUM_BURSTS itself.
    localparam int CNT_W  = $clog2(BURST_LEN + 1);
    localparam int BIDX_W = $clog2(NUM_BURSTS + 1);

    localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_RST  = ADDR_BITWIDTH_GLB'(W_READ_ADDR);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_STEP = ADDR_BITWIDTH_GLB'(BURST_LEN);
    localparam logic [CNT_W-1:0]             CNT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [BIDX_W-1:0]            BIDX_LAST = BIDX_W'(NUM_BURSTS - 1);
    localparam logic [PTR_W-1:0]             PTR_LAST  = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         state_q;
    state_t                         state_d;

    logic [PTR_W-1:0]               ptr;
    logic [PTR_W-1:0]               grant_idx;
    logic                           grant_found;
    logic                           any_valid;
    logic [DATA_BITWIDTH-1:0]       sel_data;

    logic                           v0;
    logic                           v1;
    logic                           trig;
    logic                           start_q;
    logic                           start_rise;
    logic                           burst_req;

    logic [CNT_W-1:0]               cnt;
    logic [ADDR_BITWIDTH_GLB-1:0]   base;
    logic [BIDX_W-1:0]              burst_idx;
    logic                           rsp_pending;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first pass searches from ptr upwards, second
    // pass wraps and searches from port 0.
    // ------------------------------------------------------------------
    assign any_valid = |in_enable_i;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && in_enable_i[i] && (i >= int'(ptr))) begin
                grant_idx   = PTR_W'(i);
                grant_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && in_enable_i[i]) begin
                grant_idx   = PTR_W'(i);
                grant_found = 1'b1;
            end
        end
    end

    assign sel_data = any_valid ? in_data_i[int'(grant_idx)*DATA_BITWIDTH +: DATA_BITWIDTH]
                                : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (any_valid) begin
            // Explicit wrap keeps non-power-of-two port counts correct.
            ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Forwarding is purely combinational and ignores the burst FSM.
    // ------------------------------------------------------------------
    always_comb begin
        out_enable_o = route_mask & {NUM_PORTS{any_valid}};
        out_data_o   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (route_mask[k] && any_valid) begin
                out_data_o[k*DATA_BITWIDTH +: DATA_BITWIDTH] = sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Burst triggers. The traffic edge goes through two flops, so trig
    // lands one cycle after any_valid rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            start_q <= 1'b0;
        end else begin
            v0      <= any_valid;
            v1      <= v0;
            start_q <= start;
        end
    end

    assign trig       = v0 & ~v1;
    assign start_rise = start & ~start_q;
    assign burst_req  = trig | start_rise;

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        glb_req_read = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (burst_req) begin
                    state_d = READ;
                end
            end
            READ: begin
                glb_req_read = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Requests that arrive while a burst is running are discarded.
        drop = burst_req & busy;
    end

    assign glb_addr_read = base + ADDR_BITWIDTH_GLB'(cnt);

    // ------------------------------------------------------------------
    // Burst counters and base address
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            base      <= BASE_RST;
            burst_idx <= '0;
        end else begin
            if (state_q == IDLE && burst_req) begin
                cnt <= '0;
            end else if (state_q == READ) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state_q == DONE) begin
                if (burst_idx == BIDX_LAST) begin
                    base      <= BASE_RST;
                    burst_idx <= '0;
                end else begin
                    base      <= base + BASE_STEP;
                    burst_idx <= burst_idx + BIDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scratchpad write path. A GLB response appears on the ports one
    // cycle after its request; it is captured here one cycle later still.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pending   <= 1'b0;
            spad_enable_o <= 1'b0;
            spad_data_o   <= '0;
            spad_addr_o   <= '0;
        end else begin
            rsp_pending   <= glb_req_read;
            spad_enable_o <= rsp_pending;
            spad_data_o   <= sel_data;
            if (state_q == IDLE && burst_req) begin
                spad_addr_o <= '0;
            end else if (spad_enable_o) begin
                spad_addr_o <= spad_addr_o + ADDR_BITWIDTH_SPAD'(1);
            end
        end
    end

endmodule

// File: doc/router_wght_rr.md
ROUTER_WGHT_RR -- requirements
Module: router_wght_rr

Interface
REQ-001 Parameter DATA_BITWIDTH, default 16: width of every data word.
REQ-002 Parameter ADDR_BITWIDTH_GLB, default 10: GLB read address width.
REQ-003 Parameter ADDR_BITWIDTH_SPAD, default 9: scratchpad write address width.
REQ-004 Parameter NUM_PORTS, default 4: number of router input/output channels, >=2.
REQ-005 Parameter BURST_LEN, default 9: weights fetched per burst (kernel_size squared), >=1.
REQ-006 Parameter NUM_BURSTS, default 4: bursts before the read address wraps, >=1.
REQ-007 Parameter W_READ_ADDR, default 0: GLB base read address.
REQ-008 clk  in  1  single clock; all state updates on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 in_data_i  in  NUM_PORTS*DATA_BITWIDTH  packed input words; port k occupies bits [k*DW +: DW].
REQ-011 in_enable_i  in  NUM_PORTS  per-port input valid.
REQ-012 route_mask  in  NUM_PORTS  output ports that receive the forwarded word.
REQ-013 start  in  1  software burst trigger, level sampled each cycle.
REQ-014 out_data_o  out  NUM_PORTS*DATA_BITWIDTH  forwarded words, same packing as in_data_i.
REQ-015 out_enable_o  out  NUM_PORTS  per-port forward valid.
REQ-016 glb_addr_read  out  ADDR_BITWIDTH_GLB  GLB read address.
REQ-017 glb_req_read  out  1  GLB read request, one word per asserted cycle.
REQ-018 spad_data_o  out  DATA_BITWIDTH  scratchpad write data.
REQ-019 spad_addr_o  out  ADDR_BITWIDTH_SPAD  scratchpad write address.
REQ-020 spad_enable_o  out  1  scratchpad write strobe.
REQ-021 busy  out  1  burst in progress; done  out  1  one-cycle end-of-burst pulse; drop  out  1  one-cycle pulse when a trigger is ignored.

Function
REQ-022 Arbitration shall be round-robin: grant the lowest index k >= ptr with in_enable_i[k]=1, else wrap and search from index 0; ptr resets to 0.
REQ-023 After any cycle with a grant to port g, ptr shall become (g+1) mod NUM_PORTS; with no grant, ptr shall hold.
REQ-024 any_valid = OR of in_enable_i; sel_data = granted port's word, or 0 when any_valid=0.
REQ-025 Forwarding shall be combinational: out_enable_o[k] = route_mask[k] & any_valid; out_data_o word k = sel_data when out_enable_o[k], else 0.
REQ-026 The traffic trigger shall be the rising edge of any_valid, registered in two stages (v0<=any_valid, v1<=v0, trig=v0&~v1), so it asserts one cycle after the rising edge.
REQ-027 Burst request = trig OR rising edge of start (start registered once for edge detection).
REQ-028 FSM states: IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-029 IDLE->READ on a burst request; cnt<=0; busy=1 in every state except IDLE.
REQ-030 READ: glb_req_read=1, glb_addr_read=base+cnt, cnt increments; after BURST_LEN request cycles go to DRAIN.
REQ-031 DRAIN lasts one cycle and covers the 1-cycle GLB read latency; DRAIN->DONE.
REQ-032 DONE: done=1 for one cycle; base advances by BURST_LEN, or returns to W_READ_ADDR when the burst just completed was burst NUM_BURSTS-1; DONE->IDLE.
REQ-033 A read response arrives on the ports the cycle after its request; rsp_pending shall be glb_req_read delayed by one cycle.
REQ-034 spad_enable_o and spad_data_o shall be registered: in cycle c+1 they equal rsp_pending(c) and sel_data(c); spad_addr_o starts at 0 each burst and increments after every write.
REQ-035 A burst request seen while busy=1 shall be ignored and shall pulse drop for one cycle; the burst in progress shall be unaffected.
REQ-036 Forwarding (REQ-025) shall be independent of FSM state.

Reset
REQ-037 While reset=1 at a clock edge: FSM->IDLE, ptr=0, base=W_READ_ADDR, cnt=0, spad_addr_o=0, v0=v1=0, start edge register=0; glb_req_read, spad_enable_o, spad_data_o, done, drop, busy are all 0.
REQ-038 Reset asserted mid-burst shall abort the burst without a done pulse; the next burst starts at W_READ_ADDR.

Verification
REQ-039 in_enable_i=4'b1111 held for 4 cycles, route_mask=4'b0101 -> grants 0,1,2,3 in order; out_enable_o=4'b0101.
REQ-040 in_enable_i 0->4'b0010 at cycle 10 -> trig at 11; glb_req_read=1 in cycles 12-20 at addresses 0..8; spad_enable_o=1 in cycles 14-22 at spad_addr_o 0..8; done at 22.
REQ-041 Four consecutive start bursts -> base addresses 0, 9, 18, 27; the fifth burst reads from 0.
REQ-042 start pulsed during READ -> drop=1 for one cycle; still exactly 9 requests issued.
REQ-043 reset asserted after the 4th request -> next cycle glb_req_read=0 and busy=0; the following burst begins at address 0 with spad_addr_o=0.
REQ-044 Only port 3 enabled, then ports 0 and 3 enabled -> grant 3, then grant 0 (ptr wrapped to 0).
